// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller for the RV32I core.
// Owns the M-mode trap CSRs, arbitrates interrupts, and issues a one-cycle PC redirect.
module csr_trap_unit #(
  parameter int          NUM_LOCAL_IRQ = 16,
  parameter bit          VECTORED_EN   = 1'b1,
  parameter logic [31:0] RESET_MTVEC   = 32'h0000_0000,
  parameter int          LW            = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          csr_req_i,
  input  logic [2:0]    csr_op_i,
  input  logic [11:0]   csr_addr_i,
  input  logic [31:0]   csr_wdata_i,
  output logic [31:0]   csr_rdata_o,
  output logic          csr_illegal_o,
  input  logic          exc_valid_i,
  input  logic [30:0]   exc_code_i,
  input  logic [31:0]   exc_pc_i,
  input  logic [31:0]   exc_tval_i,
  input  logic          mret_i,
  input  logic          irq_sw_i,
  input  logic          irq_timer_i,
  input  logic          irq_ext_i,
  input  logic [LW-1:0] irq_local_i,
  output logic          irq_req_o,
  output logic          irq_pending_o,
  input  logic          irq_ack_i,
  output logic          trap_valid_o,
  output logic [31:0]   trap_pc_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  localparam logic [31:0] LOCAL_MASK = ((32'h1 << NUM_LOCAL_IRQ) - 32'h1) << 16;
  localparam logic [31:0] MIE_MASK   = LOCAL_MASK | 32'h0000_0888;

  function automatic logic [31:0] legal_mtvec(input logic [31:0] v);
    legal_mtvec = v & {30'h3FFF_FFFF, 1'b0, VECTORED_EN};
  endfunction

  logic        mstatus_mie_r;
  logic        mstatus_mpie_r;
  logic [31:0] mie_r;
  logic [31:0] mip_r;
  logic [31:0] mtvec_r;
  logic [31:0] mscratch_r;
  logic [31:0] mepc_r;
  logic [31:0] mcause_r;
  logic [31:0] mtval_r;
  logic        trap_valid_r;
  logic [31:0] trap_pc_r;

  logic [31:0] rdata_s;
  logic        addr_ok_s;
  logic [31:0] wr_val_s;
  logic        illegal_s;
  logic        csr_we_s;
  logic [31:0] mip_next_s;
  logic [31:0] irq_pend_s;
  logic        local_hit_s;
  logic [4:0]  local_code_s;
  logic [4:0]  irq_code_s;
  logic        take_exc_s;
  logic        take_irq_s;
  logic        take_mret_s;
  logic [31:0] mtvec_base_s;
  logic [31:0] irq_target_s;
  logic        unused_s;

  // CSR read mux and address decode
  always_comb begin
    rdata_s   = 32'h0000_0000;
    addr_ok_s = 1'b1;
    case (csr_addr_i)
      ADDR_MSTATUS:  rdata_s = {19'h0, 2'b11, 3'b000, mstatus_mpie_r, 3'b000, mstatus_mie_r, 3'b000};
      ADDR_MIE:      rdata_s = mie_r;
      ADDR_MTVEC:    rdata_s = mtvec_r;
      ADDR_MSCRATCH: rdata_s = mscratch_r;
      ADDR_MEPC:     rdata_s = mepc_r;
      ADDR_MCAUSE:   rdata_s = mcause_r;
      ADDR_MTVAL:    rdata_s = mtval_r;
      ADDR_MIP:      rdata_s = mip_r;
      default:       addr_ok_s = 1'b0;
    endcase
  end

  // Read-modify-write operand; funct3[2] only selects the immediate form
  always_comb begin
    case (csr_op_i[1:0])
      2'b01:   wr_val_s = csr_wdata_i;
      2'b10:   wr_val_s = rdata_s | csr_wdata_i;
      2'b11:   wr_val_s = rdata_s & ~csr_wdata_i;
      default: wr_val_s = rdata_s;
    endcase
  end

  assign illegal_s = csr_req_i & (~addr_ok_s | (csr_op_i[1:0] == 2'b00));

  // Gather interrupt sources into their mip bit positions
  always_comb begin
    mip_next_s     = 32'h0000_0000;
    mip_next_s[3]  = irq_sw_i;
    mip_next_s[7]  = irq_timer_i;
    mip_next_s[11] = irq_ext_i;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
      mip_next_s[16+i] = irq_local_i[i];
    end
  end

  assign irq_pend_s    = mip_r & mie_r;
  assign irq_pending_o = |irq_pend_s;
  assign irq_req_o     = mstatus_mie_r & irq_pending_o;
  assign local_hit_s   = |(irq_pend_s & LOCAL_MASK);

  // Highest-numbered local source wins, then MEI, MSI, MTI
  always_comb begin
    local_code_s = 5'd0;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
      local_code_s = irq_pend_s[16+i] ? 5'(16 + i) : local_code_s;
    end
    if (local_hit_s) begin
      irq_code_s = local_code_s;
    end else if (irq_pend_s[11]) begin
      irq_code_s = 5'd11;
    end else if (irq_pend_s[3]) begin
      irq_code_s = 5'd3;
    end else if (irq_pend_s[7]) begin
      irq_code_s = 5'd7;
    end else begin
      irq_code_s = 5'd0;
    end
  end

  assign take_exc_s   = exc_valid_i;
  assign take_irq_s   = ~exc_valid_i & irq_ack_i & irq_req_o;
  assign take_mret_s  = ~exc_valid_i & ~take_irq_s & mret_i;
  assign csr_we_s     = csr_req_i & ~illegal_s & ~(exc_valid_i | take_irq_s | mret_i);
  assign mtvec_base_s = {mtvec_r[31:2], 2'b00};
  assign irq_target_s = mtvec_r[0] ? (mtvec_base_s + {25'h0, irq_code_s, 2'b00}) : mtvec_base_s;

  // Architectural state update: trap entry, mret, then CSR writes
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_r  <= 1'b0;
      mstatus_mpie_r <= 1'b0;
      mie_r          <= 32'h0000_0000;
      mip_r          <= 32'h0000_0000;
      mtvec_r        <= legal_mtvec(RESET_MTVEC);
      mscratch_r     <= 32'h0000_0000;
      mepc_r         <= 32'h0000_0000;
      mcause_r       <= 32'h0000_0000;
      mtval_r        <= 32'h0000_0000;
      trap_valid_r   <= 1'b0;
      trap_pc_r      <= 32'h0000_0000;
    end else begin
      mip_r        <= mip_next_s;
      trap_valid_r <= 1'b0;
      if (take_exc_s) begin
        mepc_r         <= exc_pc_i & 32'hFFFF_FFFC;
        mcause_r       <= {1'b0, exc_code_i};
        mtval_r        <= exc_tval_i;
        mstatus_mpie_r <= mstatus_mie_r;
        mstatus_mie_r  <= 1'b0;
        trap_valid_r   <= 1'b1;
        trap_pc_r      <= mtvec_base_s;
      end else if (take_irq_s) begin
        mepc_r         <= exc_pc_i & 32'hFFFF_FFFC;
        mcause_r       <= {1'b1, 26'h0, irq_code_s};
        mtval_r        <= 32'h0000_0000;
        mstatus_mpie_r <= mstatus_mie_r;
        mstatus_mie_r  <= 1'b0;
        trap_valid_r   <= 1'b1;
        trap_pc_r      <= irq_target_s;
      end else if (take_mret_s) begin
        mstatus_mie_r  <= mstatus_mpie_r;
        mstatus_mpie_r <= 1'b1;
        trap_valid_r   <= 1'b1;
        trap_pc_r      <= mepc_r;
      end else if (csr_we_s) begin
        case (csr_addr_i)
          ADDR_MSTATUS: begin
            mstatus_mie_r  <= wr_val_s[3];
            mstatus_mpie_r <= wr_val_s[7];
          end
          ADDR_MIE:      mie_r      <= wr_val_s & MIE_MASK;
          ADDR_MTVEC:    mtvec_r    <= legal_mtvec(wr_val_s);
          ADDR_MSCRATCH: mscratch_r <= wr_val_s;
          ADDR_MEPC:     mepc_r     <= wr_val_s & 32'hFFFF_FFFC;
          ADDR_MCAUSE:   mcause_r   <= wr_val_s;
          ADDR_MTVAL:    mtval_r    <= wr_val_s;
          default:       mscratch_r <= mscratch_r;
        endcase
      end
    end
  end

  assign csr_rdata_o   = rdata_s;
  assign csr_illegal_o = illegal_s;
  assign trap_valid_o  = trap_valid_r;
  assign trap_pc_o     = trap_pc_r;
  assign unused_s      = csr_op_i[2];

endmodule
